// File: rtl/inv_key_expansion_pkg.sv
// Shared AES-128 key-schedule definitions: round count, FSM state type,
// S-box table, RotWord and the rcon table.
package inv_key_expansion_pkg;

  localparam logic [3:0] AES128_ROUNDS = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    BWD
  } ks_state_t;

  // Entry 0 is the most significant byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  // Round constant for rounds 1..10, byte in the top position.
  function automatic logic [31:0] rcon(input logic [3:0] i);
    logic [31:0] r;
    r = '0;
    case (i)
      4'd1:    r = 32'h0100_0000;
      4'd2:    r = 32'h0200_0000;
      4'd3:    r = 32'h0400_0000;
      4'd4:    r = 32'h0800_0000;
      4'd5:    r = 32'h1000_0000;
      4'd6:    r = 32'h2000_0000;
      4'd7:    r = 32'h4000_0000;
      4'd8:    r = 32'h8000_0000;
      4'd9:    r = 32'h1b00_0000;
      4'd10:   r = 32'h3600_0000;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inv_key_expansion_step.sv
// Combinational backward key-schedule step: given round key i and
// Sub(R3 ^ R2) of that key, produces round key i-1.
// Ports: words - round key {R0,R1,R2,R3}; sub_word - S-box of R3^R2;
// rcon_word - rcon of round i; prev - round key i-1.
module inv_key_step
  import inv_key_expansion_pkg::*;
(
  input  logic [127:0] words,
  input  logic [31:0]  sub_word,
  input  logic [31:0]  rcon_word,
  output logic [127:0] prev
);

  logic [31:0] w0, w1, w2, w3;

  assign w3 = words[31:0]   ^ words[63:32];
  assign w2 = words[63:32]  ^ words[95:64];
  assign w1 = words[95:64]  ^ words[127:96];
  // sub_word already holds Sub(w3), supplied by the registered S-boxes.
  assign w0 = words[127:96] ^ rot_word(sub_word) ^ rcon_word;

  assign prev = {w0, w1, w2, w3};

endmodule

// File: rtl/sbox.sv
// Registered AES S-box: one byte substitution with one cycle of latency.
// Ports: clk - clock; plain - byte to substitute; subbed - S-box of the
// byte presented on the previous cycle.
module sbox
  import inv_key_expansion_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] plain,
  output logic [7:0] subbed
);

  // NOTE: pure pipeline data, no reset; its content is never used before
  // it has been loaded from a defined input.
  always_ff @(posedge clk) begin
    subbed <= SBOX[plain];
  end

endmodule

// File: rtl/inv_key_expansion.sv
// AES-128 decryption key schedule: runs the schedule forward to round 10,
// then hands out round keys 10..0 under a valid/ready handshake.
// Ports: clk, rst (async active-high); start - begin a schedule (IDLE only);
// key_in - cipher key, [127:96] = w0; key_ready - consumer accepts key_out;
// busy - schedule in progress; key_valid - key_out/round_idx valid;
// round_idx - round number of key_out; key_out - round key {R0,R1,R2,R3}.
module inv_key_expansion
  import inv_key_expansion_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic         busy,
  output logic         key_valid,
  output logic [3:0]   round_idx,
  output logic [127:0] key_out
);

  ks_state_t    state, state_n;
  logic [127:0] r, r_n;
  logic [3:0]   ctr, ctr_n;
  logic [31:0]  sbox_in, sub_q;
  logic [31:0]  f0, f1, f2, f3;
  logic [127:0] prev;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    sbox u_sbox (
      .clk    (clk),
      .plain  (sbox_in[8*i +: 8]),
      .subbed (sub_q[8*i +: 8])
    );
  end

  // Forward step; sub_q holds Sub(R3) throughout FWD.
  assign f0 = r[127:96] ^ rot_word(sub_q) ^ rcon(ctr + 4'd1);
  assign f1 = r[95:64]  ^ f0;
  assign f2 = r[63:32]  ^ f1;
  assign f3 = r[31:0]   ^ f2;

  // Backward step; sub_q holds Sub(R3 ^ R2) throughout BWD.
  inv_key_step u_step (
    .words     (r),
    .sub_word  (sub_q),
    .rcon_word (rcon(ctr)),
    .prev      (prev)
  );

  // The S-box input is always the value that R3^R2 (BWD) or R3 (FWD) will
  // have after this edge, so sub_q matches the registers it is used with.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_n = state;
    r_n     = r;
    ctr_n   = ctr;
    sbox_in = r[31:0] ^ r[63:32];
    case (state)
      IDLE: begin
        if (start) begin
          r_n     = key_in;
          ctr_n   = '0;
          state_n = FWD;
          sbox_in = key_in[31:0];
        end
      end
      FWD: begin
        r_n   = {f0, f1, f2, f3};
        ctr_n = ctr + 4'd1;
        if (ctr == AES128_ROUNDS - 4'd1) begin
          state_n = BWD;
          sbox_in = f3 ^ f2;
        end else begin
          sbox_in = f3;
        end
      end
      BWD: begin
        if (key_ready) begin
          if (ctr != 4'd0) begin
            r_n     = prev;
            ctr_n   = ctr - 4'd1;
            sbox_in = r[31:0] ^ r[95:64];
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      r     <= '0;
      ctr   <= '0;
    end else begin
      state <= state_n;
      r     <= r_n;
      ctr   <= ctr_n;
    end
  end

  assign busy      = (state != IDLE);
  assign key_valid = (state == BWD);
  assign round_idx = ctr;
  assign key_out   = r;

endmodule

// File: tb/tb_inv_key_expansion.sv
module tb_inv_key_expansion;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         key_ready;
  logic         busy;
  logic         key_valid;
  logic [3:0]   round_idx;
  logic [127:0] key_out;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  vec_t fips[11];
  int   checks   = 0;
  int   failures = 0;

  inv_key_expansion dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .key_ready (key_ready),
    .busy      (busy),
    .key_valid (key_valid),
    .round_idx (round_idx),
    .key_out   (key_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse start and wait (bounded) for the first valid key; optionally
  // pokes start again while the schedule is in FWD.
  task automatic begin_schedule(input logic [127:0] key, input bit poke_fwd);
    int lat;
    start  = 1'b1;
    key_in = key;
    tick();
    start = 1'b0;
    check("busy_after_start", {127'd0, busy}, 128'd1);
    check("valid_in_fwd", {127'd0, key_valid}, 128'd0);
    lat = 1;
    while (!key_valid && lat < 40) begin
      if (poke_fwd && lat == 4) begin
        start  = 1'b1;
        key_in = ~key;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check("first_key_latency", 128'(lat), 128'd11);
  endtask

  // Consume FIPS round keys 10..0, comparing every cycle against the table.
  task automatic drain(input bit rand_ready, input bit poke_bwd);
    int e   = 10;
    int cyc = 0;
    bit poked = 1'b0;
    while (e >= 0 && cyc < 300) begin
      check("valid", {127'd0, key_valid}, 128'd1);
      check("round_idx", {124'd0, round_idx}, {124'd0, fips[e].idx});
      check("key_out", key_out, fips[e].key);
      key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_bwd && !poked && e == 6) begin
        start  = 1'b1;
        key_in = ~FIPS_KEY;
        poked  = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
      if (key_ready) e--;
    end
    start     = 1'b0;
    key_ready = 1'b1;
    check("drain_bound", 128'(cyc < 300), 128'd1);
    check("valid_after_k0", {127'd0, key_valid}, 128'd0);
    check("busy_after_k0", {127'd0, busy}, 128'd0);
    check("key_out_hold_k0", key_out, FIPS_KEY);
    check("round_idx_idle", {124'd0, round_idx}, 128'd0);
  endtask

  initial begin
    fips[0]  = '{4'd0,  FIPS_KEY};
    fips[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    fips[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    fips[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    fips[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    fips[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    fips[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    fips[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    fips[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    fips[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    rst       = 1'b1;
    start     = 1'b0;
    key_in    = '0;
    key_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_valid", {127'd0, key_valid}, 128'd0);
    check("rst_round_idx", {124'd0, round_idx}, 128'd0);
    check("rst_key_out", key_out, 128'd0);
    rst = 1'b0;

    // key_ready while idle has no effect.
    key_ready = 1'b1;
    tick();
    tick();
    check("idle_ready_busy", {127'd0, busy}, 128'd0);
    check("idle_ready_valid", {127'd0, key_valid}, 128'd0);

    // FIPS-197 vector with key_ready held high.
    begin_schedule(FIPS_KEY, 1'b0);
    drain(1'b0, 1'b0);

    // Back-to-back: start in the cycle right after round 0 was accepted,
    // then drain with random backpressure.
    begin_schedule(FIPS_KEY, 1'b0);
    drain(1'b1, 1'b0);

    // start pulses during FWD and BWD must be ignored.
    begin_schedule(FIPS_KEY, 1'b1);
    drain(1'b1, 1'b1);

    // Asynchronous reset in BWD at round_idx 5.
    begin_schedule(FIPS_KEY, 1'b0);
    key_ready = 1'b1;
    repeat (5) tick();
    check("pre_rst_idx", {124'd0, round_idx}, 128'd5);
    check("pre_rst_key", key_out, fips[5].key);
    rst = 1'b1;
    #1;
    check("async_rst_valid", {127'd0, key_valid}, 128'd0);
    check("async_rst_busy", {127'd0, busy}, 128'd0);
    check("async_rst_key", key_out, 128'd0);
    check("async_rst_idx", {124'd0, round_idx}, 128'd0);
    tick();
    rst = 1'b0;
    tick();
    begin_schedule(128'd0, 1'b0);
    check("zero_key_r10", key_out, ZERO_R10);
    check("zero_key_idx", {124'd0, round_idx}, 128'd10);
    repeat (11) tick();
    check("zero_key_done", {127'd0, key_valid}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
